dot_result_ctrl: RTL and testbench
==================================

# dot_result_ctrl

Sequencer for the 8x8 dot-matrix result display of the guess-number game. It accepts one-cycle guess results from the game logic and drives the matrix pattern select, with one result buffered while a display is running. Each result is held for a fixed number of scan frames, then the display blanks. It also keeps a saturating hit counter. It sits between the game FSM and the dot-matrix row/column driver, on the same scan clock.

## Interface
- FRAME_CYCLES, 8: clk_div cycles per full matrix scan (one frame); must be ≥2.
- HOLD_FRAMES, 64: frames each result is displayed; must be ≥1.
- BLINK_FRAMES, 8: frames per blink half-period; used only with DOT_BLINK_EN; must be ≥1.
- clk_div  input  1  scan clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears everything.
- clear  input  1  synchronous; clears hit_cnt and overrun.
- guess_valid  input  1  one-cycle strobe: a guess result is present.
- guess_hit  input  1  result qualifier, sampled with guess_valid: 1=correct, 0=wrong.
- disp_state  output  2  pattern select: 2'd0 blank, 2'd1 good, 2'd2 bad; 2'd3 never driven.
- disp_en  output  1  1 while a non-blank pattern is selected; the driver gates columns with it.
- busy  output  1  a result is being displayed.
- done  output  1  one-cycle pulse at the end of each displayed result.
- overrun  output  1  sticky: a result was dropped.
- hit_cnt  output  4  count of accepted hits, saturating at 15.

## Operation
- All outputs registered. Reset values: disp_state=0, disp_en=0, busy=0, done=0, overrun=0, hit_cnt=0. Internal state: FSM=IDLE, pending empty, counters 0.
- FSM states:
  - IDLE: disp_state=0, busy=0. guess_valid → SHOW with the captured guess_hit.
  - SHOW: disp_state = hit ? 1 : 2, busy=1.
- Frame counter 0..FRAME_CYCLES-1, restarted to 0 on every entry to SHOW. frame_tick asserts when it reaches FRAME_CYCLES-1.
- Hold counter loads HOLD_FRAMES-1 on entry and decrements on each frame_tick. A frame_tick with hold=0 ends the result.
- End of result: done=1 for one cycle.
  - Pending full → reload SHOW with the pending result and empty the pending slot.
  - Otherwise, a guess_valid in that same cycle → reload SHOW with it directly.
  - Otherwise → IDLE.
- guess_valid during SHOW, not coincident with end of result:
  - pending empty → store result in pending.
  - pending full → drop the new result, set overrun.
  - At end of result with pending full, a simultaneous guess_valid is stored into the freed pending slot (not dropped).
- hit_cnt increments when a hit is accepted (captured to SHOW or stored to pending), not when it is displayed. Saturates at 15. Dropped results never count.
- clear and accept in the same cycle: clear wins, and hit_cnt ends at 0.
- reset mid-display: immediately blank, pending discarded, no done pulse.

## Timing
- guess_valid sampled high at edge N in IDLE → disp_state/busy/disp_en valid after edge N (cycle N+1).
- Display length exactly FRAME_CYCLES*HOLD_FRAMES cycles. With defaults that is 512 cycles.
- done is high in the first cycle after the last display cycle. busy drops in that same cycle if going to IDLE.
- Back-to-back results: no blank cycle between them, and busy stays 1.
- overrun sets the cycle after the dropping edge.

## Configuration
- DOT_BLINK_EN defined:
  - In SHOW, a phase bit toggles on every BLINK_FRAMES-th frame_tick, counted from entry.
  - Phase starts on at every SHOW entry.
  - Phase off forces disp_state=0 and disp_en=0.
  - Display length and done timing are unchanged.
- DOT_BLINK_EN undefined: steady display; the blink counter and phase logic are not built.

## Test plan
- FRAME_CYCLES=8, HOLD_FRAMES=4: reset, then guess_valid with hit=1 → disp_state=1 and busy=1 for exactly 32 cycles, then done pulse for 1 cycle, disp_state=0, hit_cnt=1.
- Miss, then hit 5 cycles later → bad for 32 cycles, then good immediately with no blank cycle, done pulses 32 cycles apart, hit_cnt=1.
- Three guesses during one display → first shown, second buffered, third dropped, overrun=1. clear → overrun=0, hit_cnt=0.
- Reset asserted 10 cycles into SHOW with pending full → all outputs at reset values asynchronously. After release, IDLE with no done pulse.
- 17 hits each spaced ≥64 cycles → hit_cnt stops at 15.
- DOT_BLINK_EN, BLINK_FRAMES=1, HOLD_FRAMES=4 → disp_en pattern 8 on / 8 off / 8 on / 8 off, then done.

Source files
------------

// File: rtl/dot_result_ctrl_if.sv
// Guess-result and display-status bundle between game FSM and result sequencer.
// Game side is master; the sequencer is slave.
interface dot_result_ctrl_if;
  logic       clear;
  logic       guess_valid;
  logic       guess_hit;
  logic [1:0] disp_state;
  logic       disp_en;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [3:0] hit_cnt;

  modport master (
    output clear,
    output guess_valid,
    output guess_hit,
    input  disp_state,
    input  disp_en,
    input  busy,
    input  done,
    input  overrun,
    input  hit_cnt
  );

  modport slave (
    input  clear,
    input  guess_valid,
    input  guess_hit,
    output disp_state,
    output disp_en,
    output busy,
    output done,
    output overrun,
    output hit_cnt
  );
endinterface

// File: rtl/dot_result_ctrl.sv
// Dot-matrix result sequencer: shows each guess result for HOLD_FRAMES scans.
// Optional blinking display built when DOT_BLINK_EN is defined.
module dot_result_ctrl #(
  parameter int unsigned FRAME_CYCLES = 8,
  parameter int unsigned HOLD_FRAMES  = 64,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic             clk_div,
  input  logic             reset,
  dot_result_ctrl_if.slave bus
);

  localparam int unsigned FW =
    (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned HW =
    (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [FW-1:0] F_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_FRAMES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  if (FRAME_CYCLES < 2) begin : g_chk_frame
    $error("FRAME_CYCLES must be >= 2");
  end
  if (HOLD_FRAMES < 1) begin : g_chk_hold
    $error("HOLD_FRAMES must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_chk_blink
    $error("BLINK_FRAMES must be >= 1");
  end

  logic [0:0]    st_q, st_n;
  logic          hit_q, hit_n;
  logic          pv_q, pv_n;
  logic          ph_hit_q, ph_hit_n;
  logic [FW-1:0] fc_q, fc_n;
  logic [HW-1:0] hc_q, hc_n;

  logic [1:0]    ds_q;
  logic          en_q;
  logic          busy_q;
  logic          done_q;
  logic          ovr_q;
  logic [3:0]    cnt_q;

  logic          frame_tick;
  logic          end_res;
  logic          start;
  logic          acc_hit;
  logic          drop;
  logic          lit;

  assign frame_tick = (st_q == SHOW) && (fc_q == F_LAST);
  assign end_res    = frame_tick && (hc_q == '0);

  always_comb begin
    st_n     = st_q;
    hit_n    = hit_q;
    pv_n     = pv_q;
    ph_hit_n = ph_hit_q;
    fc_n     = fc_q;
    hc_n     = hc_q;
    start    = 1'b0;
    acc_hit  = 1'b0;
    drop     = 1'b0;
    unique case (1'b1)
      (st_q == IDLE): begin
        if (bus.guess_valid) begin
          start   = 1'b1;
          hit_n   = bus.guess_hit;
          acc_hit = bus.guess_hit;
        end
      end
      end_res: begin
        if (pv_q) begin
          start = 1'b1;
          hit_n = ph_hit_q;
          pv_n  = bus.guess_valid;
          if (bus.guess_valid) begin
            ph_hit_n = bus.guess_hit;
            acc_hit  = bus.guess_hit;
          end
        end else if (bus.guess_valid) begin
          start   = 1'b1;
          hit_n   = bus.guess_hit;
          acc_hit = bus.guess_hit;
        end else begin
          st_n = IDLE;
        end
      end
      default: begin
        fc_n = frame_tick ? '0 : fc_q + FW'(1);
        if (frame_tick)
          hc_n = hc_q - HW'(1);
        if (bus.guess_valid) begin
          if (!pv_q) begin
            pv_n     = 1'b1;
            ph_hit_n = bus.guess_hit;
            acc_hit  = bus.guess_hit;
          end else begin
            drop = 1'b1;
          end
        end
      end
    endcase
    // Every entry or reload restarts both timing counters.
    if (start) begin
      st_n = SHOW;
      fc_n = '0;
      hc_n = H_LAST;
    end
  end

`ifdef DOT_BLINK_EN
  localparam int unsigned BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bc_q, bc_n;
  logic          ph_q, ph_n;

  always_comb begin
    bc_n = bc_q;
    ph_n = ph_q;
    if (start) begin
      bc_n = '0;
      ph_n = 1'b1;
    end else if (frame_tick) begin
      if (bc_q == B_LAST) begin
        bc_n = '0;
        ph_n = ~ph_q;
      end else begin
        bc_n = bc_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      bc_q <= '0;
      ph_q <= 1'b0;
    end else begin
      bc_q <= bc_n;
      ph_q <= ph_n;
    end
  end

  assign lit = ph_n;
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      hit_q    <= 1'b0;
      pv_q     <= 1'b0;
      ph_hit_q <= 1'b0;
      fc_q     <= '0;
      hc_q     <= '0;
      ds_q     <= 2'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      st_q     <= st_n;
      hit_q    <= hit_n;
      pv_q     <= pv_n;
      ph_hit_q <= ph_hit_n;
      fc_q     <= fc_n;
      hc_q     <= hc_n;
      busy_q   <= (st_n == SHOW);
      done_q   <= end_res;
      en_q     <= (st_n == SHOW) && lit;
      if ((st_n == SHOW) && lit)
        ds_q <= hit_n ? 2'd1 : 2'd2;
      else
        ds_q <= 2'd0;
      // Clear beats a same-cycle accept or drop.
      if (bus.clear) begin
        ovr_q <= 1'b0;
        cnt_q <= 4'd0;
      end else begin
        if (drop)
          ovr_q <= 1'b1;
        if (acc_hit && (cnt_q != 4'd15))
          cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign bus.disp_state = ds_q;
  assign bus.disp_en    = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = ovr_q;
  assign bus.hit_cnt    = cnt_q;

endmodule

// File: tb/tb_dot_result_ctrl.sv
// Scoreboard bench for dot_result_ctrl with FRAME_CYCLES=8, HOLD_FRAMES=4.
// Expected displayed results are queued at stimulus, checked at each done.
module tb_dot_result_ctrl;

  localparam int SEG_LEN = 32;
`ifdef DOT_BLINK_EN
  localparam int SEG_ON = 16;
`else
  localparam int SEG_ON = 32;
`endif

  typedef struct {
    int st;
    int gap;
  } exp_t;

  logic clk_div = 1'b0;
  logic reset   = 1'b1;

  dot_result_ctrl_if bus ();

  dot_result_ctrl #(
    .FRAME_CYCLES(8),
    .HOLD_FRAMES (4),
    .BLINK_FRAMES(1)
  ) dut (
    .clk_div(clk_div),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_div = ~clk_div;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  int ncyc      = 0;
  int last_done = 0;
  int dones     = 0;
  int seg_len   = 0;
  int seg_on    = 0;
  int seg_st    = 0;
  int seg_bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: segments are the busy cycles between done pulses.
  always @(negedge clk_div) begin
    ncyc++;
    if (reset) begin
      seg_len = 0;
      seg_on  = 0;
      seg_st  = 0;
      seg_bad = 0;
    end else begin
      if (bus.done) begin
        dones++;
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("seg_state", seg_st, e.st);
          chk("seg_len", seg_len, SEG_LEN);
          chk("seg_on", seg_on, SEG_ON);
          chk("seg_steady", seg_bad, 0);
          if (e.gap != 0)
            chk("done_gap", ncyc - last_done, e.gap);
        end
        last_done = ncyc;
        seg_len   = 0;
        seg_on    = 0;
        seg_st    = 0;
        seg_bad   = 0;
      end
      if (bus.busy) begin
        if (seg_len == 0)
          seg_st = int'(bus.disp_state);
        else if (bus.disp_en && int'(bus.disp_state) != seg_st)
          seg_bad = 1;
        if (bus.disp_en != (bus.disp_state != 2'd0))
          seg_bad = 1;
        seg_len++;
        if (bus.disp_en)
          seg_on++;
      end else if (bus.disp_en || bus.disp_state != 2'd0) begin
        seg_bad = 1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_div);
    #1;
  endtask

  task automatic guess(input logic hit, input int st, input int gap);
    @(posedge clk_div);
    #1;
    bus.guess_valid = 1'b1;
    bus.guess_hit   = hit;
    if (st != 0)
      q.push_back('{st: st, gap: gap});
    @(posedge clk_div);
    #1;
    bus.guess_valid = 1'b0;
    bus.guess_hit   = 1'b0;
  endtask

  initial begin
    int d0;
    bus.clear       = 1'b0;
    bus.guess_valid = 1'b0;
    bus.guess_hit   = 1'b0;
    cycles(3);
    chk("rst_disp_state", int'(bus.disp_state), 0);
    chk("rst_disp_en", int'(bus.disp_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_hit_cnt", int'(bus.hit_cnt), 0);
    #2 reset = 1'b0;
    cycles(2);

    // Single hit
    guess(1'b1, 1, 0);
    chk("hit_busy", int'(bus.busy), 1);
    chk("hit_state", int'(bus.disp_state), 1);
    chk("hit_en", int'(bus.disp_en), 1);
    cycles(40);
    chk("hit_cnt1", int'(bus.hit_cnt), 1);
    chk("idle_state", int'(bus.disp_state), 0);
    chk("idle_busy", int'(bus.busy), 0);

    // Miss then buffered hit, shown back to back
    guess(1'b0, 2, 0);
    cycles(3);
    guess(1'b1, 1, SEG_LEN);
    cycles(80);
    chk("hit_cnt2", int'(bus.hit_cnt), 2);

    // Three guesses in one display: show, buffer, drop
    guess(1'b1, 1, 0);
    cycles(1);
    guess(1'b1, 1, SEG_LEN);
    cycles(1);
    chk("no_overrun_yet", int'(bus.overrun), 0);
    guess(1'b0, 0, 0);
    chk("overrun_set", int'(bus.overrun), 1);
    chk("hit_cnt_drop", int'(bus.hit_cnt), 4);
    cycles(80);
    chk("overrun_sticky", int'(bus.overrun), 1);
    bus.clear = 1'b1;
    cycles(1);
    bus.clear = 1'b0;
    chk("clr_overrun", int'(bus.overrun), 0);
    chk("clr_hit_cnt", int'(bus.hit_cnt), 0);

    // Clear and accept together: accepted, not counted
    bus.clear = 1'b1;
    guess(1'b1, 1, 0);
    bus.clear = 1'b0;
    chk("clr_acc_busy", int'(bus.busy), 1);
    chk("clr_acc_cnt", int'(bus.hit_cnt), 0);
    cycles(40);

    // Saturation
    for (int i = 0; i < 17; i++) begin
      guess(1'b1, 1, 0);
      cycles(62);
    end
    chk("hit_cnt_sat", int'(bus.hit_cnt), 15);

    // Reset during display with pending full
    guess(1'b1, 0, 0);
    guess(1'b0, 0, 0);
    cycles(7);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_state", int'(bus.disp_state), 0);
    chk("arst_en", int'(bus.disp_en), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_cnt", int'(bus.hit_cnt), 0);
    chk("arst_overrun", int'(bus.overrun), 0);
    #7 reset = 1'b0;
    d0 = dones;
    cycles(80);
    chk("post_rst_dones", dones - d0, 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
